// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encodings and
// product-width helper.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add/subtract row: adds (or, on the signed MSB step, subtracts) the
// extended multiplicand into the accumulator and shifts right by one. Combinational.
module mult_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] x_r,
    input  logic             y_bit,
    input  logic             mode_r,
    input  logic             is_msb,
    output logic [WIDTH:0]   acc_next,
    output logic             shift_out
);

    logic [WIDTH:0]   x_ext;
    logic [WIDTH+1:0] term;
    logic [WIDTH+1:0] sum;

    always_comb begin
        x_ext = {mode_r & x_r[WIDTH-1], x_r};
        term  = y_bit ? {x_ext[WIDTH], x_ext} : '0;
        // The signed multiplier MSB carries negative weight.
        if (mode_r && is_msb) begin
            sum = {acc[WIDTH], acc} - term;
        end else begin
            sum = {acc[WIDTH], acc} + term;
        end
        acc_next  = sum[WIDTH+1:1];
        shift_out = sum[0];
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, one multiplier bit per cycle; done pulses
// WIDTH edges after start is sampled. start is ignored while busy.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = prod_width(WIDTH);

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [WIDTH-1:0] x_q,       x_d;
    logic [WIDTH-1:0] y_q,       y_d;
    logic [WIDTH:0]   acc_q,     acc_d;
    logic             mode_q,    mode_d;
    logic [PW-1:0]    product_q, product_d;

    logic [WIDTH:0]   acc_next;
    logic             shift_out;
    logic             is_msb;

    assign is_msb = (count_q == CNT_W'(WIDTH - 1));

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc_q),
        .x_r       (x_q),
        .y_bit     (y_q[0]),
        .mode_r    (mode_q),
        .is_msb    (is_msb),
        .acc_next  (acc_next),
        .shift_out (shift_out)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        x_d       = x_q;
        y_d       = y_q;
        acc_d     = acc_q;
        mode_d    = mode_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    mode_d  = signed_mode;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Low product bits collect in y as the multiplier bits retire.
                acc_d   = acc_next;
                y_d     = {shift_out, y_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (is_msb) begin
                    state_d   = ST_DONE;
                    product_d = {acc_next[WIDTH-1:0], shift_out, y_q[WIDTH-1:1]};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            acc_q     <= '0;
            mode_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            x_q       <= x_d;
            y_q       <= y_d;
            acc_q     <= acc_d;
            mode_q    <= mode_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule
